// File: rtl/rgb_pwm_fader_if.sv
// ---------------------------------------------------------------------------
// rgb_pwm_fader_if
// Colour-command handshake between the blink-pattern decoder (master) and
// the RGB PWM fader (slave).
//   COLOR_IN   [2:0]      colour code, [2]=R [1]=G [0]=B       master -> slave
//   COLOR_VLD             command valid                         master -> slave
//   LEVEL_MAX  [PWM_W-1:0] on-brightness for this command       master -> slave
//   COLOR_RDY             slave idle, command accepted when set slave -> master
// ---------------------------------------------------------------------------
interface rgb_pwm_fader_if #(
    parameter int PWM_W = 8
);
    logic [2:0]       COLOR_IN;
    logic             COLOR_VLD;
    logic [PWM_W-1:0] LEVEL_MAX;
    logic             COLOR_RDY;

    modport master (
        output COLOR_IN,
        output COLOR_VLD,
        output LEVEL_MAX,
        input  COLOR_RDY
    );

    modport slave (
        input  COLOR_IN,
        input  COLOR_VLD,
        input  LEVEL_MAX,
        output COLOR_RDY
    );
endinterface

// File: rtl/rgb_pwm_fader.sv
// ---------------------------------------------------------------------------
// rgb_pwm_fader
// Drives the board RGB LED with PWM and fades each channel linearly from its
// current brightness to the target given by the last accepted colour command.
//
// Parameters
//   PWM_W          brightness / PWM counter width; PWM period = 2^PWM_W-1
//   FADE_STEP_CYC  clock cycles per 1-LSB brightness step while fading (>= 1)
//
// Ports
//   CLK        in   system clock
//   ff2_RST    in   asynchronous active-high reset (synchronised upstream)
//   color_if   slave modport: COLOR_IN, COLOR_VLD, LEVEL_MAX in; COLOR_RDY out
//   BUSY       out  fade in progress (inverse of COLOR_RDY)
//   LED_PWM    out  registered PWM pin drive, [2]=R [1]=G [0]=B
//
// Build option
//   RGB_PWM_GAMMA_EN  when defined, duty = level^2 >> PWM_W (full scale kept
//                     full on), registered, giving 2 cycles level-to-pin.
//                     Otherwise duty = level, 1 cycle level-to-pin.
// ---------------------------------------------------------------------------
module rgb_pwm_fader #(
    parameter int PWM_W         = 8,
    parameter int FADE_STEP_CYC = 65536
) (
    input  logic             CLK,
    input  logic             ff2_RST,
    rgb_pwm_fader_if.slave   color_if,
    output logic             BUSY,
    output logic [2:0]       LED_PWM
);

    localparam int STEP_W = (FADE_STEP_CYC > 1) ? $clog2(FADE_STEP_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_CYC - 1);
    localparam logic [PWM_W-1:0]  PWM_TOP   = '1;
    // Counter stops one short of all-ones so that a duty of all-ones is
    // strictly greater than every count value (pin constantly high).
    localparam logic [PWM_W-1:0]  CNT_LAST  = {{(PWM_W-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              load;
    logic              step_en;
    logic [2:0]        chan_match;

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK or posedge ff2_RST) begin
        if (ff2_RST) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        load       = 1'b0;
        step_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (color_if.COLOR_VLD) begin
                    load       = 1'b1;
                    state_d    = FADE;
                    step_cnt_d = '0;
                end
            end
            FADE: begin
                // Completion is evaluated on current levels, so a command
                // matching the present levels leaves FADE after one cycle.
                if (&chan_match) begin
                    state_d = IDLE;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_en    = 1'b1;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;

    assign color_if.COLOR_RDY = (state_q == IDLE);
    assign BUSY               = (state_q == FADE);

    // ---------------- per-channel datapath ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [PWM_W-1:0] level_q, level_d;
            logic [PWM_W-1:0] target_q, target_d;
            logic [PWM_W-1:0] duty;
            logic             pin_q;

            always_comb begin
                target_d = target_q;
                level_d  = level_q;
                if (load) begin
                    target_d = color_if.COLOR_IN[gi] ? color_if.LEVEL_MAX : '0;
                end
                // Single-LSB move toward target: cannot overshoot or wrap.
                if (step_en) begin
                    if (level_q < target_q) begin
                        level_d = level_q + 1'b1;
                    end else if (level_q > target_q) begin
                        level_d = level_q - 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or posedge ff2_RST) begin
                if (ff2_RST) begin
                    level_q  <= '0;
                    target_q <= '0;
                end else begin
                    level_q  <= level_d;
                    target_q <= target_d;
                end
            end

            assign chan_match[gi] = (level_q == target_q);

`ifdef RGB_PWM_GAMMA_EN
            logic [2*PWM_W-1:0] level_sq;
            logic [PWM_W-1:0]   duty_q;

            assign level_sq = {{PWM_W{1'b0}}, level_q} * {{PWM_W{1'b0}}, level_q};

            // Plain squaring would cap below full scale; force full on.
            always_ff @(posedge CLK or posedge ff2_RST) begin
                if (ff2_RST) begin
                    duty_q <= '0;
                end else begin
                    duty_q <= (level_q == PWM_TOP) ? PWM_TOP : level_sq[2*PWM_W-1:PWM_W];
                end
            end

            assign duty = duty_q;
`else
            assign duty = level_q;
`endif

            always_ff @(posedge CLK or posedge ff2_RST) begin
                if (ff2_RST) begin
                    pin_q <= 1'b0;
                end else begin
                    pin_q <= (duty > pwm_cnt_q);
                end
            end

            assign LED_PWM[gi] = pin_q;
        end
    endgenerate

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_fader
// Directed test of rgb_pwm_fader with PWM_W=4, FADE_STEP_CYC=2.
// Brightness is observed on the pins by counting high cycles over one full
// 15-cycle PWM period (equals the duty regardless of counter phase).
// ---------------------------------------------------------------------------
module tb_rgb_pwm_fader;

    localparam int PWM_W = 4;
    localparam int STEP  = 2;
`ifdef RGB_PWM_GAMMA_EN
    localparam int DUTY7 = 3;   // 49 >> 4
    localparam int DUTY8 = 4;   // 64 >> 4
`else
    localparam int DUTY7 = 7;
    localparam int DUTY8 = 8;
`endif

    logic       CLK;
    logic       ff2_RST;
    logic       BUSY;
    logic [2:0] LED_PWM;

    int n_tests;
    int n_fail;

    rgb_pwm_fader_if #(.PWM_W(PWM_W)) cif ();

    rgb_pwm_fader #(
        .PWM_W        (PWM_W),
        .FADE_STEP_CYC(STEP)
    ) dut (
        .CLK     (CLK),
        .ff2_RST (ff2_RST),
        .color_if(cif),
        .BUSY    (BUSY),
        .LED_PWM (LED_PWM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transfer edge; caller must be in IDLE.
    task automatic send(input logic [2:0] code, input logic [PWM_W-1:0] lvl);
        @(negedge CLK);
        cif.COLOR_IN  = code;
        cif.LEVEL_MAX = lvl;
        cif.COLOR_VLD = 1'b1;
        tick();
        cif.COLOR_VLD = 1'b0;
    endtask

    // Edges until COLOR_RDY returns, bounded.
    task automatic wait_rdy(output int n);
        n = 0;
        while (cif.COLOR_RDY !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic measure(output int r, output int g, output int b, output int nonuni);
        r = 0; g = 0; b = 0; nonuni = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            r += int'(LED_PWM[2]);
            g += int'(LED_PWM[1]);
            b += int'(LED_PWM[0]);
            if (LED_PWM != 3'b000 && LED_PWM != 3'b111) nonuni++;
        end
    endtask

    int n, r, g, b, nu, any_hi;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cif.COLOR_IN  = 3'b000;
        cif.COLOR_VLD = 1'b0;
        cif.LEVEL_MAX = '0;
        ff2_RST       = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        ff2_RST = 1'b0;
        #1;

        // Reset state
        check_eq("rst_led", int'(LED_PWM), 0);
        check_eq("rst_rdy", int'(cif.COLOR_RDY), 1);
        check_eq("rst_busy", int'(BUSY), 0);
        any_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (LED_PWM != 3'b000) any_hi++;
        end
        check_eq("idle_led_quiet", any_hi, 0);

        // Red 0 -> 15
        send(3'b100, 4'd15);
        check_eq("r_up_rdy_low", int'(cif.COLOR_RDY), 0);
        check_eq("r_up_busy", int'(BUSY), 1);
        wait_rdy(n);
        check_eq("r_up_cycles", n, 15 * STEP + 1);
        check_eq("r_up_busy_end", int'(BUSY), 0);
        measure(r, g, b, nu);
        check_eq("r_up_duty_r", r, 15);
        check_eq("r_up_duty_gb", g + b, 0);

        // R down, G up concurrently
        send(3'b010, 4'd15);
        wait_rdy(n);
        check_eq("rg_cross_cycles", n, 15 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("rg_cross_r", r, 0);
        check_eq("rg_cross_g", g, 15);
        check_eq("rg_cross_b", b, 0);

        // Command pulsed mid-fade is ignored
        send(3'b100, 4'd15);
        repeat (4) tick();
        send(3'b001, 4'd15);
        wait_rdy(n);
        check_eq("ignore_cycles", n + 5, 15 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("ignore_r", r, 15);
        check_eq("ignore_g", g, 0);
        check_eq("ignore_b", b, 0);

        // LEVEL_MAX=0 with all channels on fades everything off
        send(3'b111, 4'd0);
        wait_rdy(n);
        check_eq("lvl0_cycles", n, 15 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("lvl0_sum", r + g + b, 0);

        // White at level 7, all in phase
        send(3'b111, 4'd7);
        wait_rdy(n);
        check_eq("w7_cycles", n, 7 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("w7_r", r, DUTY7);
        check_eq("w7_g", g, DUTY7);
        check_eq("w7_b", b, DUTY7);
        check_eq("w7_in_phase", nu, 0);

        // Same target: exactly one cycle in FADE
        send(3'b111, 4'd7);
        wait_rdy(n);
        check_eq("same_tgt_cycles", n, 1);

        // Reset mid-fade
        send(3'b100, 4'd15);
        repeat (5) tick();
        @(negedge CLK);
        ff2_RST = 1'b1;
        #1;
        check_eq("arst_led", int'(LED_PWM), 0);
        check_eq("arst_rdy", int'(cif.COLOR_RDY), 1);
        check_eq("arst_busy", int'(BUSY), 0);
        @(negedge CLK);
        ff2_RST = 1'b0;
        send(3'b100, 4'd15);
        wait_rdy(n);
        check_eq("post_rst_cycles", n, 15 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("post_rst_r", r, 15);

        // Mid-scale level 8 (gamma-dependent duty); 15 -> 8 is 7 steps
        send(3'b100, 4'd8);
        wait_rdy(n);
        check_eq("l8_cycles", n, 7 * STEP + 1);
        measure(r, g, b, nu);
        check_eq("l8_r", r, DUTY8);

        // VLD held across completion: accepted on the following cycle
        @(negedge CLK);
        cif.COLOR_IN  = 3'b100;
        cif.LEVEL_MAX = 4'd8;
        cif.COLOR_VLD = 1'b1;
        tick();                       // transfer, same target
        tick();                       // completion edge, VLD ignored
        check_eq("held_rdy_after_done", int'(cif.COLOR_RDY), 1);
        tick();                       // re-accepted
        check_eq("held_reaccept_busy", int'(BUSY), 1);
        cif.COLOR_VLD = 1'b0;
        wait_rdy(n);
        check_eq("held_reaccept_cycles", n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
